// File: rtl/mult_pipe_mac.sv
// Pipelined signed/unsigned multiplier with valid tag and configurable latency.
// Define MULT_PIPE_MAC_ACC_EN to build the wrapping accumulator with sticky overflow.
module mult_pipe_mac #(
    parameter int WIDTH_A   = 16,
    parameter int WIDTH_B   = 16,
    parameter int LATENCY   = 3,
    parameter int ACC_WIDTH = 40
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       CE,
    input  logic                       IN_VALID,
    input  logic                       SIGNED,
    input  logic                       ACC_CLR,
    input  logic [WIDTH_A-1:0]         A,
    input  logic [WIDTH_B-1:0]         B,
    output logic [WIDTH_A+WIDTH_B-1:0] P,
    output logic                       P_VALID,
    output logic [ACC_WIDTH-1:0]       ACC,
    output logic                       ACC_VALID,
    output logic                       ACC_OVF
);

    localparam int PW = WIDTH_A + WIDTH_B;

    logic [WIDTH_A-1:0] a_q;
    logic [WIDTH_B-1:0] b_q;
    logic               s1_sgn_q;
    logic               s1_clr_q;
    logic               s1_vld_q;

    logic [PW-1:0]      prod_q [2:LATENCY];
    logic [LATENCY:2]   sgn_q;
    logic [LATENCY:2]   clr_q;
    logic [LATENCY:2]   vld_q;

    logic [PW-1:0]      ax;
    logic [PW-1:0]      bx;
    logic [PW-1:0]      prod_d;

    // Extending past width+1 to PW bits keeps the low PW bits of the product exact.
    assign ax     = {{WIDTH_B{s1_sgn_q & a_q[WIDTH_A-1]}}, a_q};
    assign bx     = {{WIDTH_A{s1_sgn_q & b_q[WIDTH_B-1]}}, b_q};
    assign prod_d = ax * bx;

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q      <= '0;
            b_q      <= '0;
            s1_sgn_q <= 1'b0;
            s1_clr_q <= 1'b0;
            s1_vld_q <= 1'b0;
            sgn_q    <= '0;
            clr_q    <= '0;
            vld_q    <= '0;
            for (int k = 2; k <= LATENCY; k++) begin
                prod_q[k] <= '0;
            end
        end else if (CE) begin
            s1_vld_q <= IN_VALID;
            if (IN_VALID) begin
                a_q      <= A;
                b_q      <= B;
                s1_sgn_q <= SIGNED;
                s1_clr_q <= ACC_CLR;
            end
            vld_q[2] <= s1_vld_q;
            sgn_q[2] <= s1_sgn_q;
            clr_q[2] <= s1_clr_q;
            if (s1_vld_q) begin
                prod_q[2] <= prod_d;
            end
            // Data only moves with a valid tag, so the last stage holds the last product.
            for (int k = 3; k <= LATENCY; k++) begin
                vld_q[k] <= vld_q[k-1];
                sgn_q[k] <= sgn_q[k-1];
                clr_q[k] <= clr_q[k-1];
                if (vld_q[k-1]) begin
                    prod_q[k] <= prod_q[k-1];
                end
            end
        end
    end

    assign P       = prod_q[LATENCY];
    assign P_VALID = CE & vld_q[LATENCY];

`ifdef MULT_PIPE_MAC_ACC_EN
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [ACC_WIDTH-1:0] base;
    logic [ACC_WIDTH-1:0] p_ext;
    logic signed [PW:0]   p_s;
    logic                 accv_q;
    logic                 ovf_q;
    logic                 ovf_d;

    assign p_s   = {sgn_q[LATENCY] & P[PW-1], P};
    assign p_ext = ACC_WIDTH'(p_s);

    always_comb begin
        base  = clr_q[LATENCY] ? '0 : acc_q;
        acc_d = base + p_ext;
        ovf_d = (clr_q[LATENCY] ? 1'b0 : ovf_q)
              | ((base[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1])
                 && (acc_d[ACC_WIDTH-1] != base[ACC_WIDTH-1]));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q  <= '0;
            accv_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (CE) begin
            accv_q <= vld_q[LATENCY];
            if (vld_q[LATENCY]) begin
                acc_q <= acc_d;
                ovf_q <= ovf_d;
            end
        end
    end

    assign ACC       = acc_q;
    assign ACC_VALID = CE & accv_q;
    assign ACC_OVF   = ovf_q;
`else
    logic unused_acc;

    assign unused_acc = ^{clr_q[LATENCY], sgn_q[LATENCY]};
    assign ACC        = '0;
    assign ACC_VALID  = 1'b0;
    assign ACC_OVF    = 1'b0;
`endif

endmodule

// File: tb/tb_mult_pipe_mac.sv
// Directed bench for mult_pipe_mac (LATENCY=3, 16x16, ACC_WIDTH=32).
// Accumulator expectations follow MULT_PIPE_MAC_ACC_EN; otherwise they are 0.
module tb_mult_pipe_mac;

`ifdef MULT_PIPE_MAC_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic        CLK;
    logic        RST;
    logic        CE;
    logic        IN_VALID;
    logic        SIGNED;
    logic        ACC_CLR;
    logic [15:0] A;
    logic [15:0] B;
    logic [31:0] P;
    logic        P_VALID;
    logic [31:0] ACC;
    logic        ACC_VALID;
    logic        ACC_OVF;

    int n_err = 0;
    int n_chk = 0;

    mult_pipe_mac #(
        .WIDTH_A  (16),
        .WIDTH_B  (16),
        .LATENCY  (3),
        .ACC_WIDTH(32)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .CE       (CE),
        .IN_VALID (IN_VALID),
        .SIGNED   (SIGNED),
        .ACC_CLR  (ACC_CLR),
        .A        (A),
        .B        (B),
        .P        (P),
        .P_VALID  (P_VALID),
        .ACC      (ACC),
        .ACC_VALID(ACC_VALID),
        .ACC_OVF  (ACC_OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ce, input logic v, input logic s,
                         input logic clr, input logic [15:0] a,
                         input logic [15:0] b);
        CE       = ce;
        IN_VALID = v;
        SIGNED   = s;
        ACC_CLR  = clr;
        A        = a;
        B        = b;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // CE stall stream
    logic        ce4  [12] = '{1,1,0,0,0,0,0,1,1,1,1,1};
    logic        v4   [12] = '{1,1,1,1,1,1,1,1,1,0,0,0};
    logic [15:0] a4   [12] = '{2,4,16'hDEAD,16'hDEAD,16'hDEAD,16'hDEAD,
                               16'hDEAD,6,8,0,0,0};
    logic [15:0] b4   [12] = '{3,5,16'hBEEF,16'hBEEF,16'hBEEF,16'hBEEF,
                               16'hBEEF,7,9,0,0,0};
    logic        pv4  [12] = '{0,0,0,0,0,0,0,1,1,1,1,0};
    logic [31:0] p4   [12] = '{32'hFFFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF,
                               32'hFFFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF,
                               32'hFFFFFFFF,6,20,42,72,72};

    // Accumulate stream
    logic [15:0] a6   [8] = '{3,5,7,1,0,0,0,0};
    logic [15:0] b6   [8] = '{4,6,8,1,0,0,0,0};
    logic        v6   [8] = '{1,1,1,1,0,0,0,0};
    logic        c6   [8] = '{1,0,0,1,0,0,0,0};
    logic        pv6  [8] = '{0,0,1,1,1,1,0,0};
    logic [31:0] p6   [8] = '{0,0,12,30,56,1,1,1};
    logic        av6  [8] = '{0,0,0,1,1,1,1,0};
    logic [31:0] acc6 [8] = '{0,0,0,12,42,98,1,1};

    // Signed overflow stream
    logic [15:0] a7   [9] = '{16'h7FFF,16'h7FFF,16'h7FFF,16'h7FFF,1,0,0,0,0};
    logic        v7   [9] = '{1,1,1,1,1,0,0,0,0};
    logic        c7   [9] = '{1,0,0,0,1,0,0,0,0};
    logic        pv7  [9] = '{0,0,1,1,1,1,1,0,0};
    logic [31:0] p7   [9] = '{1,1,32'h3FFF0001,32'h3FFF0001,32'h3FFF0001,
                              32'h3FFF0001,1,1,1};
    logic        av7  [9] = '{0,0,0,1,1,1,1,1,0};
    logic [31:0] acc7 [9] = '{1,1,1,32'h3FFF0001,32'h7FFE0002,32'hBFFD0003,
                              32'hFFFC0004,1,1};
    logic        ov7  [9] = '{0,0,0,0,0,1,1,0,0};

    initial begin
        RST = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst_p", P, 0);
        chk("rst_pv", P_VALID, 0);
        chk("rst_acc", ACC, 0);
        chk("rst_accv", ACC_VALID, 0);
        chk("rst_ovf", ACC_OVF, 0);
        RST = 1'b0;

        // unsigned max, latency 3
        drive(1, 1, 0, 0, 16'hFFFF, 16'hFFFF);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("umax_pv_c0", P_VALID, 0);
        tick();
        chk("umax_pv_c1", P_VALID, 0);
        tick();
        chk("umax_pv_c2", P_VALID, 1);
        chk("umax_p", P, 32'hFFFE0001);
        tick();
        chk("umax_pv_c3", P_VALID, 0);
        chk("umax_hold", P, 32'hFFFE0001);

        // signed corners back-to-back
        drive(1, 1, 1, 0, 16'h8000, 16'h8000);
        tick();
        chk("sgn_pv_c0", P_VALID, 0);
        drive(1, 1, 1, 0, 16'hFFFF, 16'h0001);
        tick();
        chk("sgn_pv_c1", P_VALID, 0);
        drive(1, 0, 0, 0, 0, 0);
        tick();
        chk("sgn_pv_c2", P_VALID, 1);
        chk("sgn_p_min", P, 32'h40000000);
        tick();
        chk("sgn_pv_c3", P_VALID, 1);
        chk("sgn_p_m1", P, 32'hFFFFFFFF);
        tick();
        chk("sgn_pv_c4", P_VALID, 0);

        // CE stall of 5 cycles after the second sample
        for (int c = 0; c < 12; c++) begin
            drive(ce4[c], v4[c], 0, 0, a4[c], b4[c]);
            tick();
            chk($sformatf("stall_pv_c%0d", c), P_VALID, pv4[c]);
            chk($sformatf("stall_p_c%0d", c), P, p4[c]);
        end

        // reset with two samples in flight
        drive(1, 1, 0, 0, 3, 3);
        tick();
        drive(1, 1, 0, 0, 5, 5);
        tick();
        RST = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        tick();
        RST = 1'b0;
        chk("midrst_p", P, 0);
        chk("midrst_pv", P_VALID, 0);
        chk("midrst_acc", ACC, 0);
        chk("midrst_accv", ACC_VALID, 0);
        chk("midrst_ovf", ACC_OVF, 0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("midrst_pv_c%0d", c), P_VALID, 0);
        end

        // accumulate with clear
        for (int c = 0; c < 8; c++) begin
            drive(1, v6[c], 0, c6[c], a6[c], b6[c]);
            tick();
            chk($sformatf("acc_pv_c%0d", c), P_VALID, pv6[c]);
            chk($sformatf("acc_p_c%0d", c), P, p6[c]);
            chk($sformatf("acc_accv_c%0d", c), ACC_VALID, ACC_EN & av6[c]);
            chk($sformatf("acc_acc_c%0d", c), ACC, ACC_EN ? acc6[c] : 32'd0);
            chk($sformatf("acc_ovf_c%0d", c), ACC_OVF, 0);
        end

        // signed overflow wrap, sticky until the next clear
        for (int c = 0; c < 9; c++) begin
            drive(1, v7[c], 1, c7[c], a7[c], a7[c]);
            tick();
            chk($sformatf("ovf_pv_c%0d", c), P_VALID, pv7[c]);
            chk($sformatf("ovf_p_c%0d", c), P, p7[c]);
            chk($sformatf("ovf_accv_c%0d", c), ACC_VALID, ACC_EN & av7[c]);
            chk($sformatf("ovf_acc_c%0d", c), ACC, ACC_EN ? acc7[c] : 32'd0);
            chk($sformatf("ovf_flag_c%0d", c), ACC_OVF, ACC_EN & ov7[c]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
